pos_sweep_checker: RTL and testbench

Sequential stimulus-and-capture engine for the 4-input, 2-output sum/product logic blocks in this guide set. It drives the input vector {x,y,w,z} through all 16 combinations in ascending order, with x as MSB and z as LSB. At each combination it samples the two block outputs (s1 = unsimplified form, s2 = simplified form) and reports both truth tables, a per-vector mismatch map, and an equivalence flag. It replaces hand-written `#1` stimulus lists with a synthesizable self-check.

---
 rtl/pos_sweep_if.sv | 31 +++
 rtl/pos_sweep_checker.sv | 135 +++++++++++++
 tb/tb_pos_sweep_checker.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pos_sweep_if.sv
// Bus between the sweep checker and the logic block it exercises:
// start request, block outputs s1/s2, driven vector, status and results.
interface pos_sweep_if;
  localparam int unsigned MAP_W = 16;
  localparam int unsigned CNT_W = 5;

  logic             start;
  logic             s1;
  logic             s2;
  logic             x;
  logic             y;
  logic             w;
  logic             z;
  logic             busy;
  logic             done;
  logic [MAP_W-1:0] s1_map;
  logic [MAP_W-1:0] s2_map;
  logic [MAP_W-1:0] mismatch_map;
  logic [CNT_W-1:0] mismatch_cnt;
  logic             equiv;

  modport master (
    output start, s1, s2,
    input  x, y, w, z, busy, done, s1_map, s2_map, mismatch_map, mismatch_cnt, equiv
  );

  modport slave (
    input  start, s1, s2,
    output x, y, w, z, busy, done, s1_map, s2_map, mismatch_map, mismatch_cnt, equiv
  );
endinterface

// File: rtl/pos_sweep_checker.sv
// Sweeps {x,y,w,z} through 0..15, samples s1/s2 after a settle delay at each
// vector, and builds truth-table maps, a mismatch map/count and an equivalence flag.
module pos_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  pos_sweep_if.slave bus
);
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned WCNT_W = 8;
  localparam int unsigned MAP_W  = 16;
  localparam int unsigned CNT_W  = 5;
  // A zero settle time would never leave SETTLE cleanly; run it as one cycle.
  localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(SETTLE_EFF - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state,    state_nx;
  logic [IDX_W-1:0]   idx,      idx_nx;
  logic [WCNT_W-1:0]  wcnt,     wcnt_nx;
  logic [MAP_W-1:0]   s1_map,   s1_map_nx;
  logic [MAP_W-1:0]   s2_map,   s2_map_nx;
  logic [MAP_W-1:0]   mm_map,   mm_map_nx;
  logic [CNT_W-1:0]   mm_cnt,   mm_cnt_nx;
  logic               busy,     busy_nx;
  logic               done,     done_nx;
  logic               equiv,    equiv_nx;
  logic               mis_c;

  assign mis_c = bus.s1 ^ bus.s2;

  // State register and all datapath/status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      wcnt   <= '0;
      s1_map <= '0;
      s2_map <= '0;
      mm_map <= '0;
      mm_cnt <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      equiv  <= 1'b1;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      wcnt   <= wcnt_nx;
      s1_map <= s1_map_nx;
      s2_map <= s2_map_nx;
      mm_map <= mm_map_nx;
      mm_cnt <= mm_cnt_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      equiv  <= equiv_nx;
    end
  end

  // Next-state, datapath updates and registered status derived from the next state.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    wcnt_nx   = wcnt;
    s1_map_nx = s1_map;
    s2_map_nx = s2_map;
    mm_map_nx = mm_map;
    mm_cnt_nx = mm_cnt;

    case (state)
      ST_IDLE: begin
        idx_nx = '0;
        if (bus.start) begin
          s1_map_nx = '0;
          s2_map_nx = '0;
          mm_map_nx = '0;
          mm_cnt_nx = '0;
          wcnt_nx   = '0;
          state_nx  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (wcnt == WCNT_LAST) begin
          wcnt_nx  = '0;
          state_nx = ST_SAMPLE;
        end else begin
          wcnt_nx = wcnt + WCNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        s1_map_nx[idx] = bus.s1;
        s2_map_nx[idx] = bus.s2;
        mm_map_nx[idx] = mis_c;
        mm_cnt_nx      = mm_cnt + CNT_W'(mis_c);
        if (idx == IDX_LAST) begin
          state_nx = ST_DONE;
        end else begin
          idx_nx   = idx + IDX_W'(1);
          state_nx = ST_SETTLE;
        end
      end
      ST_DONE: begin
        idx_nx   = '0;
        state_nx = ST_IDLE;
      end
      default: begin
        idx_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase

    busy_nx  = (state_nx == ST_SETTLE) || (state_nx == ST_SAMPLE);
    done_nx  = (state_nx == ST_DONE);
    equiv_nx = (mm_cnt_nx == '0);
  end

  assign bus.x            = idx[3];
  assign bus.y            = idx[2];
  assign bus.w            = idx[1];
  assign bus.z            = idx[0];
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.s1_map       = s1_map;
  assign bus.s2_map       = s2_map;
  assign bus.mismatch_map = mm_map;
  assign bus.mismatch_cnt = mm_cnt;
  assign bus.equiv        = equiv;
endmodule

// File: tb/tb_pos_sweep_checker.sv
// Directed and randomized checks of pos_sweep_checker at SETTLE=1 and SETTLE=3,
// with the block under test modelled as a 16-entry truth table per output.
module tb_pos_sweep_checker;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   sel;

  logic [15:0] tt1;
  logic [15:0] tt2;

  logic        m_busy;
  logic        m_done;
  logic        m_equiv;
  logic [3:0]  m_vec;
  logic [15:0] m_s1;
  logic [15:0] m_s2;
  logic [15:0] m_mm;
  logic [4:0]  m_cnt;

  pos_sweep_if if1 ();
  pos_sweep_if if3 ();

  pos_sweep_checker #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  pos_sweep_checker #(.SETTLE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block under test: each output is a lookup in its truth table.
  always_comb begin
    if1.s1 = tt1[{if1.x, if1.y, if1.w, if1.z}];
    if1.s2 = tt2[{if1.x, if1.y, if1.w, if1.z}];
    if3.s1 = tt1[{if3.x, if3.y, if3.w, if3.z}];
    if3.s2 = tt2[{if3.x, if3.y, if3.w, if3.z}];
  end

  always_comb begin
    if (sel == 3) begin
      m_busy = if3.busy; m_done = if3.done; m_equiv = if3.equiv;
      m_vec  = {if3.x, if3.y, if3.w, if3.z};
      m_s1 = if3.s1_map; m_s2 = if3.s2_map; m_mm = if3.mismatch_map; m_cnt = if3.mismatch_cnt;
    end else begin
      m_busy = if1.busy; m_done = if1.done; m_equiv = if1.equiv;
      m_vec  = {if1.x, if1.y, if1.w, if1.z};
      m_s1 = if1.s1_map; m_s2 = if1.s2_map; m_mm = if1.mismatch_map; m_cnt = if1.mismatch_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 3) if3.start = v;
    else            if1.start = v;
  endtask

  task automatic chk_idle_clear(input string tag);
    chk({tag, "_busy"},  32'(m_busy),  32'd0);
    chk({tag, "_done"},  32'(m_done),  32'd0);
    chk({tag, "_vec"},   32'(m_vec),   32'd0);
    chk({tag, "_s1"},    32'(m_s1),    32'd0);
    chk({tag, "_s2"},    32'(m_s2),    32'd0);
    chk({tag, "_mm"},    32'(m_mm),    32'd0);
    chk({tag, "_cnt"},   32'(m_cnt),   32'd0);
    chk({tag, "_equiv"}, 32'(m_equiv), 32'd1);
  endtask

  // Results are all cleared by the accepting edge and the sweep begins at vector 0.
  task automatic chk_accepted();
    chk("acc_busy",  32'(m_busy),  32'd1);
    chk("acc_done",  32'(m_done),  32'd0);
    chk("acc_vec",   32'(m_vec),   32'd0);
    chk("acc_mm",    32'(m_mm),    32'd0);
    chk("acc_s1",    32'(m_s1),    32'd0);
    chk("acc_cnt",   32'(m_cnt),   32'd0);
    chk("acc_equiv", 32'(m_equiv), 32'd1);
  endtask

  task automatic kick(input int which, input bit hold);
    sel = which;
    @(posedge clk); #1;
    set_start(which, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_start(which, 1'b0);
    chk_accepted();
  endtask

  // Walks one sweep cycle by cycle from just after the accepting edge.
  task automatic run_body(input int s, input bit poke);
    int len;
    len = 16 * (s + 1);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      if (poke && k == 10) set_start(sel, 1'b1);
      if (poke && k == 11) set_start(sel, 1'b0);
      chk("vec",  32'(m_vec),  (k < len) ? 32'(k / (s + 1)) : 32'd15);
      chk("busy", 32'(m_busy), 32'(k < len));
      chk("done", 32'(m_done), 32'(k == len));
    end
  endtask

  task automatic chk_results(input string tag);
    logic [15:0] mm;
    mm = tt1 ^ tt2;
    chk({tag, "_s1map"}, 32'(m_s1),    32'(tt1));
    chk({tag, "_s2map"}, 32'(m_s2),    32'(tt2));
    chk({tag, "_mmap"},  32'(m_mm),    32'(mm));
    chk({tag, "_cnt"},   32'(m_cnt),   32'($countones(mm)));
    chk({tag, "_equiv"}, 32'(m_equiv), 32'(mm == 16'd0));
  endtask

  // After done: one IDLE cycle with results still held.
  task automatic chk_after_done(input string tag);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, 32'(m_busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(m_done), 32'd0);
    chk({tag, "_idle_vec"},  32'(m_vec),  32'd0);
    chk_results({tag, "_hold"});
  endtask

  task automatic load_reference();
    for (int i = 0; i < 16; i++) begin
      logic bx, by, bw, bz;
      bx = i[3]; by = i[2]; bw = i[1]; bz = i[0];
      tt1[i] = (bx | ~by | bw | bz) & (~bx | by | bw | bz) & (~bx | by | bw | ~bz)
             & (~bx | ~by | bw | bz) & (~bx | ~by | bw | ~bz);
      tt2[i] = bw | ((~by | bz) & ~bx);
    end
  endtask

  initial begin
    int n;
    total = 0; bad = 0; sel = 1;
    if1.start = 1'b0; if3.start = 1'b0;
    tt1 = '0; tt2 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_clear("rst1");
    sel = 3; #0;
    chk_idle_clear("rst3");
    @(negedge clk); rst_n = 1'b1;

    // Reference pair at SETTLE=1: equivalent, known truth table.
    load_reference();
    kick(1, 1'b0);
    run_body(1, 1'b0);
    chk("ref_s1map", 32'(m_s1), 32'h0000_CCEF);
    chk("ref_s2map", 32'(m_s2), 32'h0000_CCEF);
    chk("ref_mmap",  32'(m_mm), 32'd0);
    chk("ref_cnt",   32'(m_cnt), 32'd0);
    chk("ref_equiv", 32'(m_equiv), 32'd1);
    chk_after_done("ref");

    // Forced mismatch: s2 stuck at 0.
    tt2 = 16'h0000;
    kick(1, 1'b0);
    run_body(1, 1'b0);
    chk("fm_mmap",  32'(m_mm),    32'h0000_CCEF);
    chk("fm_cnt",   32'(m_cnt),   32'd11);
    chk("fm_equiv", 32'(m_equiv), 32'd0);
    chk("fm_s2map", 32'(m_s2),    32'd0);
    chk_after_done("fm");

    // All sixteen vectors mismatch: count reaches 16 without wrap.
    tt1 = 16'hFFFF; tt2 = 16'h0000;
    kick(1, 1'b0);
    run_body(1, 1'b0);
    chk("all_cnt", 32'(m_cnt), 32'd16);
    chk_results("all");

    // Random truth tables, including one equivalent pair.
    for (int r = 0; r < 4; r++) begin
      tt1 = 16'($urandom);
      tt2 = (r == 0) ? tt1 : 16'($urandom);
      kick(1, 1'b0);
      run_body(1, 1'b0);
      chk_results("rnd1");
    end

    // SETTLE=3: four cycles per vector, with a start poke mid-sweep.
    tt1 = 16'($urandom); tt2 = 16'($urandom);
    kick(3, 1'b0);
    run_body(3, 1'b0);
    chk_results("s3");
    chk_after_done("s3");
    kick(3, 1'b0);
    run_body(3, 1'b1);
    chk_results("s3poke");
    chk_after_done("s3poke");

    // Asynchronous reset in the middle of vector 7.
    load_reference();
    kick(1, 1'b0);
    n = 0;
    while (m_vec != 4'd7 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_reach7", 32'(m_vec), 32'd7);
    chk("rst_partial", 32'(m_s1 != 16'd0), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_idle_clear("midrst");
    @(negedge clk); rst_n = 1'b1;
    kick(1, 1'b0);
    run_body(1, 1'b0);
    chk("post_s1map", 32'(m_s1), 32'h0000_CCEF);
    chk("post_s2map", 32'(m_s2), 32'h0000_CCEF);
    chk_results("post");

    // start held high: back-to-back sweeps, period 16*(SETTLE+1)+2.
    tt1 = 16'($urandom); tt2 = 16'($urandom);
    kick(1, 1'b1);
    run_body(1, 1'b0);
    chk_results("b2b_a");
    chk_after_done("b2b_a");
    tt1 = ~tt1;
    @(posedge clk); #1;
    chk_accepted();
    run_body(1, 1'b0);
    chk_results("b2b_b");
    set_start(1, 1'b0);
    chk_after_done("b2b_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
